// File: rtl/seg7_pkg.sv
// Shared seven-segment helpers: blank pattern, digit decoder and converter state type.
package seg7_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } conv_state_t;

   // Active-low {g,f,e,d,c,b,a}; nibbles above 9 show nothing.
   function automatic logic [6:0] seg7_dec(input logic [3:0] d);
      case (d)
         4'd0:    return 7'h40;
         4'd1:    return 7'h79;
         4'd2:    return 7'h24;
         4'd3:    return 7'h30;
         4'd4:    return 7'h19;
         4'd5:    return 7'h12;
         4'd6:    return 7'h02;
         4'd7:    return 7'h78;
         4'd8:    return 7'h00;
         4'd9:    return 7'h10;
         default: return SEG_BLANK;
      endcase
   endfunction

   function automatic longint unsigned pow10(input int unsigned n);
      longint unsigned p;
      p = 1;
      for (int unsigned i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronises an active-low raw key and emits one pulse per debounced press.
module key_debounce #(
   parameter int unsigned DEB_CYC = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic press_pulse
);

   localparam int unsigned CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
   localparam logic [CW-1:0] LAST = CW'(DEB_CYC - 1);

   logic          sync1;
   logic          sync2;
   logic          armed;
   logic [CW-1:0] stable_cnt;

   // armed=1 waits for a stable low, armed=0 waits for a stable high, so a
   // synced level equal to armed is always the "wrong" level and restarts the count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1       <= 1'b1;
         sync2       <= 1'b1;
         armed       <= 1'b1;
         stable_cnt  <= '0;
         press_pulse <= 1'b0;
      end else begin
         sync1       <= key_n;
         sync2       <= sync1;
         press_pulse <= 1'b0;
         if (sync2 == armed) begin
            stable_cnt <= '0;
         end else if (stable_cnt == LAST) begin
            stable_cnt  <= '0;
            armed       <= ~armed;
            press_pulse <= armed;
         end else begin
            stable_cnt <= stable_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/seg7_updown_counter.sv
// Two-key bounded up/down counter with sequential double-dabble conversion
// and an 8-digit leading-zero-blanked seven-segment readout.
module seg7_updown_counter
   import seg7_pkg::*;
#(
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned NUM_DIG = 5,
   parameter int unsigned MAX_VAL = 9999,
   parameter int unsigned DEB_CYC = 1_000_000,
   parameter int unsigned WRAP    = 1
) (
   input  logic             CLOCK_50,
   input  logic             rst_n,
   input  logic             key_up,
   input  logic             key_down,
   output logic [CNT_W-1:0] count,
   output logic             busy,
   output logic [6:0]       oSEG0,
   output logic [6:0]       oSEG1,
   output logic [6:0]       oSEG2,
   output logic [6:0]       oSEG3,
   output logic [6:0]       oSEG4,
   output logic [6:0]       oSEG5,
   output logic [6:0]       oSEG6,
   output logic [6:0]       oSEG7
);

   if (NUM_DIG < 1 || NUM_DIG > 8) begin : g_bad_num_dig
      $error("seg7_updown_counter: NUM_DIG must be 1..8");
   end
   if (CNT_W < 1 || CNT_W > 26) begin : g_bad_cnt_w
      $error("seg7_updown_counter: CNT_W must be 1..26");
   end
   if (longint'(MAX_VAL) >= (64'd1 << CNT_W) || longint'(MAX_VAL) >= pow10(NUM_DIG)) begin : g_bad_max
      $error("seg7_updown_counter: MAX_VAL does not fit CNT_W or NUM_DIG");
   end

   localparam int unsigned       SH_W    = $clog2(CNT_W + 1);
   localparam logic [CNT_W-1:0]  MAX_C   = CNT_W'(MAX_VAL);
   localparam logic [SH_W-1:0]   SH_LAST = SH_W'(CNT_W - 1);

   logic             up_pulse;
   logic             dn_pulse;
   logic [CNT_W-1:0] count_nxt;
   logic             pending;
   logic             pending_nxt;
   conv_state_t      state;
   logic [CNT_W-1:0] bin;
   logic [31:0]      bcd;
   logic [31:0]      bcd_adj;
   logic [31:0]      disp;
   logic [SH_W-1:0]  sh_cnt;
   logic [6:0]       seg_q   [8];
   logic [6:0]       seg_nxt [8];
   logic [3:0]       nib;
   logic             seen;

   key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_up (
      .clk         (CLOCK_50),
      .rst_n       (rst_n),
      .key_n       (key_up),
      .press_pulse (up_pulse)
   );

   key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_down (
      .clk         (CLOCK_50),
      .rst_n       (rst_n),
      .key_n       (key_down),
      .press_pulse (dn_pulse)
   );

   always_comb begin
      count_nxt = count;
      if (up_pulse && !dn_pulse) begin
         if (count == MAX_C) count_nxt = (WRAP != 0) ? '0 : MAX_C;
         else                count_nxt = count + 1'b1;
      end else if (dn_pulse && !up_pulse) begin
         if (count == '0) count_nxt = (WRAP != 0) ? MAX_C : '0;
         else             count_nxt = count - 1'b1;
      end
   end

   assign pending_nxt = pending | (count_nxt != count);

   always_comb begin
      bcd_adj = bcd;
      for (int unsigned k = 0; k < 8; k++) begin
         if (bcd[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
      end
   end

   // IDLE looks at pending_nxt so a conversion can start on the same edge the
   // count changes; that is what keeps count-to-display latency at CNT_W+2.
   always_ff @(posedge CLOCK_50) begin
      if (!rst_n) begin
         count   <= '0;
         pending <= 1'b1;
         state   <= IDLE;
         busy    <= 1'b0;
         bin     <= '0;
         bcd     <= '0;
         sh_cnt  <= '0;
         disp    <= '0;
      end else begin
         count   <= count_nxt;
         pending <= pending_nxt;
         case (state)
            IDLE: begin
               if (pending_nxt) begin
                  bin     <= count_nxt;
                  bcd     <= '0;
                  sh_cnt  <= '0;
                  busy    <= 1'b1;
                  pending <= 1'b0;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               {bcd, bin} <= {bcd_adj, bin} << 1;
               sh_cnt     <= sh_cnt + 1'b1;
               if (sh_cnt == SH_LAST) state <= DONE;
            end
            DONE: begin
               disp  <= bcd;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Scan from the top digit down so "seen" tells whether any higher digit is non-zero.
   always_comb begin
      seg_nxt = '{default: SEG_BLANK};
      seen    = 1'b0;
      nib     = '0;
      for (int unsigned k = 0; k < 8; k++) begin
         nib  = disp[4*(7-k) +: 4];
         seen = seen | (nib != 4'd0);
         if ((7 - k) < NUM_DIG && ((7 - k) == 0 || seen)) seg_nxt[7-k] = seg7_dec(nib);
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (!rst_n) seg_q <= '{0: seg7_dec(4'd0), default: SEG_BLANK};
      else        seg_q <= seg_nxt;
   end

   assign oSEG0 = seg_q[0];
   assign oSEG1 = seg_q[1];
   assign oSEG2 = seg_q[2];
   assign oSEG3 = seg_q[3];
   assign oSEG4 = seg_q[4];
   assign oSEG5 = seg_q[5];
   assign oSEG6 = seg_q[6];
   assign oSEG7 = seg_q[7];

endmodule

// File: tb/tb_seg7_updown_counter.sv
// Randomised bench for seg7_updown_counter: a wrapping 0..9999 instance and a
// saturating 0..20 two-digit instance share the keys and are checked against a decimal model.
module tb_seg7_updown_counter;

   localparam int unsigned CW = 16;
   localparam logic [6:0] SEG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   logic          clk = 1'b0;
   logic          rst_n;
   logic          key_up;
   logic          key_down;
   logic [CW-1:0] count_a, count_b;
   logic          busy_a, busy_b;
   logic [6:0]    seg_a [8];
   logic [6:0]    seg_b [8];

   always #5 clk = ~clk;

   seg7_updown_counter #(.CNT_W(CW), .NUM_DIG(5), .MAX_VAL(9999), .DEB_CYC(4), .WRAP(1)) dut_a (
      .CLOCK_50(clk), .rst_n(rst_n), .key_up(key_up), .key_down(key_down),
      .count(count_a), .busy(busy_a),
      .oSEG0(seg_a[0]), .oSEG1(seg_a[1]), .oSEG2(seg_a[2]), .oSEG3(seg_a[3]),
      .oSEG4(seg_a[4]), .oSEG5(seg_a[5]), .oSEG6(seg_a[6]), .oSEG7(seg_a[7])
   );

   seg7_updown_counter #(.CNT_W(CW), .NUM_DIG(2), .MAX_VAL(20), .DEB_CYC(4), .WRAP(0)) dut_b (
      .CLOCK_50(clk), .rst_n(rst_n), .key_up(key_up), .key_down(key_down),
      .count(count_b), .busy(busy_b),
      .oSEG0(seg_b[0]), .oSEG1(seg_b[1]), .oSEG2(seg_b[2]), .oSEG3(seg_b[3]),
      .oSEG4(seg_b[4]), .oSEG5(seg_b[5]), .oSEG6(seg_b[6]), .oSEG7(seg_b[7])
   );

   int n_chk = 0;
   int n_err = 0;
   int cnt_a = 0;
   int cnt_b = 0;

   // Event logger for instance A, sampled on the falling edge.
   int         cyc = 0;
   int         t_cnt = 0, t_seg = 0;
   int         busy_rise = 0, n_cnt_chg = 0;
   bit         log_en = 1'b0;
   logic [6:0] seg_log [$];
   logic [CW-1:0] last_cnt = '0;
   logic [6:0]    last_seg0 = 7'h40;
   logic          last_busy = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (count_a !== last_cnt) begin
         t_cnt = cyc;
         last_cnt = count_a;
         if (log_en) n_cnt_chg++;
      end
      if (seg_a[0] !== last_seg0) begin
         t_seg = cyc;
         last_seg0 = seg_a[0];
         if (log_en) seg_log.push_back(seg_a[0]);
      end
      if (busy_a === 1'b1 && last_busy === 1'b0 && log_en) busy_rise++;
      last_busy = busy_a;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int step(input int c, input bit up, input bit dn, input int mx, input bit wrap);
      if (up && !dn) return (c == mx) ? (wrap ? 0 : mx) : c + 1;
      if (dn && !up) return (c == 0) ? (wrap ? mx : 0) : c - 1;
      return c;
   endfunction

   function automatic logic [6:0] exp_seg(input int v, input int i, input int nd);
      int p;
      p = 1;
      for (int k = 0; k < i; k++) p = p * 10;
      if (i >= nd || (i > 0 && v < p)) return 7'h7F;
      return SEG_TAB[(v / p) % 10];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_press(input bit u, input bit d);
      cnt_a = step(cnt_a, u, d, 9999, 1'b1);
      cnt_b = step(cnt_b, u, d, 20, 1'b0);
   endtask

   task automatic press(input bit u, input bit d, input int nb);
      for (int i = 0; i < nb; i++) begin
         bit b;
         b = 1'($urandom_range(0, 1));
         if (u) key_up = b;
         if (d) key_down = b;
         tick();
      end
      if (u) key_up = 1'b0;
      if (d) key_down = 1'b0;
      repeat (10) tick();
      key_up = 1'b1;
      key_down = 1'b1;
      repeat (10) tick();
      model_press(u, d);
   endtask

   task automatic check_all(input string tag);
      @(negedge clk);
      check({tag, ".count_a"}, 32'(count_a), cnt_a);
      check({tag, ".count_b"}, 32'(count_b), cnt_b);
      check({tag, ".busy_a"}, 32'(busy_a), 0);
      check({tag, ".busy_b"}, 32'(busy_b), 0);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("%s.seg_a%0d", tag, i), 32'(seg_a[i]), 32'(exp_seg(cnt_a, i, 5)));
         check($sformatf("%s.seg_b%0d", tag, i), 32'(seg_b[i]), 32'(exp_seg(cnt_b, i, 2)));
      end
   endtask

   task automatic reset_pulse();
      key_up = 1'b1;
      key_down = 1'b1;
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      cnt_a = 0;
      cnt_b = 0;
      repeat (30) tick();
   endtask

   initial begin
      rst_n = 1'b0;
      key_up = 1'b1;
      key_down = 1'b1;
      repeat (3) tick();
      check_all("reset");
      rst_n = 1'b1;
      repeat (30) tick();

      // Bouncy press: exactly one increment, display follows CNT_W+2 cycles later.
      key_up = 1'b0; tick();
      key_up = 1'b1; tick();
      key_up = 1'b0; tick();
      repeat (10) tick();
      key_up = 1'b1;
      repeat (20) tick();
      model_press(1'b1, 1'b0);
      check("bounce.latency", 32'(t_seg - t_cnt), CW + 2);
      check_all("bounce");

      for (int i = 0; i < 122; i++) press(1'b1, 1'b0, 0);
      repeat (10) tick();
      check_all("up123");

      reset_pulse();
      press(1'b0, 1'b1, 1);
      repeat (10) tick();
      check_all("down_at_0");
      press(1'b1, 1'b0, 2);
      repeat (10) tick();
      check_all("up_at_max");

      log_en = 1'b1;
      busy_rise = 0;
      n_cnt_chg = 0;
      press(1'b1, 1'b1, 0);
      repeat (10) tick();
      log_en = 1'b0;
      tick();
      check("both.busy_rise", busy_rise, 0);
      check("both.cnt_changes", n_cnt_chg, 0);
      check_all("both");

      // Second press lands while the first conversion is still shifting.
      begin
         int mid, fin;
         mid = step(cnt_a, 1'b1, 1'b0, 9999, 1'b1);
         fin = step(mid, 1'b1, 1'b0, 9999, 1'b1);
         seg_log.delete();
         busy_rise = 0;
         log_en = 1'b1;
         key_up = 1'b0; repeat (8) tick();
         key_up = 1'b1; repeat (6) tick();
         key_up = 1'b0; repeat (8) tick();
         key_up = 1'b1; repeat (40) tick();
         log_en = 1'b0;
         tick();
         model_press(1'b1, 1'b0);
         model_press(1'b1, 1'b0);
         check("overlap.busy_rise", busy_rise, 2);
         check("overlap.seg_changes", seg_log.size(), 2);
         if (seg_log.size() == 2) begin
            check("overlap.seg_mid", 32'(seg_log[0]), 32'(exp_seg(mid, 0, 5)));
            check("overlap.seg_fin", 32'(seg_log[1]), 32'(exp_seg(fin, 0, 5)));
         end
         check_all("overlap");
      end

      for (int n = 0; n < 40; n++) begin
         int op;
         op = int'($urandom_range(0, 2));
         case (op)
            0:       press(1'b1, 1'b0, int'($urandom_range(0, 3)));
            1:       press(1'b0, 1'b1, int'($urandom_range(0, 3)));
            default: press(1'b1, 1'b1, 0);
         endcase
         repeat (10) tick();
         check_all($sformatf("rand%0d", n));
      end

      // Reset in the middle of a conversion.
      begin
         int w;
         w = 0;
         key_up = 1'b0;
         while (busy_a !== 1'b1 && w < 40) begin
            tick();
            w++;
         end
         check("midshift.busy_seen", 32'(busy_a), 1);
         repeat (3) tick();
         rst_n = 1'b0;
         tick();
         key_up = 1'b1;
         cnt_a = 0;
         cnt_b = 0;
         check_all("midshift_reset");
         rst_n = 1'b1;
         repeat (30) tick();
         check_all("after_reset");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_chk, n_err);
      $fatal(1, "watchdog expired");
   end

endmodule
